// File: rtl/washer_pkg.sv
// Shared washer definitions: spin FSM encoding, fault bit positions,
// default plant/threshold constants and saturating arithmetic helpers.
package washer_pkg;

  typedef enum logic [1:0] {
    SP_IDLE = 2'd0,
    SP_UP   = 2'd1,
    SP_RUN  = 2'd2,
    SP_DOWN = 2'd3
  } spin_state_t;

  localparam int FLT_CONFLICT   = 0;
  localparam int FLT_OVERFLOW   = 1;
  localparam int FLT_DRY_HEAT   = 2;
  localparam int FLT_UNBALANCED = 3;

  localparam int         DEF_TICK_DIV     = 1;
  localparam logic [7:0] DEF_LEVEL_MAX    = 8'd200;
  localparam logic [7:0] DEF_FILL_RATE    = 8'd4;
  localparam logic [7:0] DEF_DRAIN_RATE   = 8'd8;
  localparam logic [7:0] DEF_FULL_THRESH  = 8'd160;
  localparam logic [7:0] DEF_EMPTY_THRESH = 8'd8;
  localparam logic [7:0] DEF_TEMP_INIT    = 8'd15;
  localparam logic [7:0] DEF_TEMP_TARGET  = 8'd40;
  localparam logic [7:0] DEF_HEAT_DIV     = 8'd10;
  localparam logic [7:0] DEF_COOL_DIV     = 8'd50;
  localparam logic [7:0] DEF_RPM_STEP     = 8'd16;
  localparam logic [7:0] DEF_RPM_MAX      = 8'd240;
  localparam logic [7:0] DEF_AGIT_PERIOD  = 8'd5;

  // a + b clamped to lim; the 9-bit sum keeps the carry visible
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] lim);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= {1'b0, lim}) ? lim : sum[7:0];
  endfunction

  // a - b clamped at zero
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

endpackage

// File: rtl/washer_plant_if.sv
// Actuator/sensor bundle between the washer controller (master) and the
// behavioural plant (slave).
interface washer_plant_if;
  logic       water_in;
  logic       wash;
  logic       drain;
  logic       speed;
  logic       heat_r;
  logic       full;
  logic       empty;
  logic       cold;
  logic [7:0] level;
  logic [7:0] temp;
  logic [7:0] rpm;
  logic       agit_dir;
  logic [3:0] fault;

  modport master (
    output water_in, wash, drain, speed, heat_r,
    input  full, empty, cold, level, temp, rpm, agit_dir, fault
  );

  modport slave (
    input  water_in, wash, drain, speed, heat_r,
    output full, empty, cold, level, temp, rpm, agit_dir, fault
  );
endinterface

// File: rtl/washer_tick_gen.sv
// Plant time-base prescaler: one-cycle tick every TICK_DIV clocks, first
// tick TICK_DIV cycles after reset release. TICK_DIV=1 keeps tick high.
module washer_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  // free-running divider that wraps on the tick cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (o_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/washer_plant.sv
// Behavioural washer plant: tank level, water temperature, agitator and
// spin motor driven by controller actuator commands, with sticky faults.
// Optional macro WASHER_PLANT_HYST_EN turns full/empty into tick-registered
// hysteresis flags; without it they are a direct threshold decode.
module washer_plant
  import washer_pkg::*;
#(
  parameter int         TICK_DIV     = DEF_TICK_DIV,
  parameter logic [7:0] LEVEL_MAX    = DEF_LEVEL_MAX,
  parameter logic [7:0] FILL_RATE    = DEF_FILL_RATE,
  parameter logic [7:0] DRAIN_RATE   = DEF_DRAIN_RATE,
  parameter logic [7:0] FULL_THRESH  = DEF_FULL_THRESH,
  parameter logic [7:0] EMPTY_THRESH = DEF_EMPTY_THRESH,
  parameter logic [7:0] TEMP_INIT    = DEF_TEMP_INIT,
  parameter logic [7:0] TEMP_TARGET  = DEF_TEMP_TARGET,
  parameter logic [7:0] HEAT_DIV     = DEF_HEAT_DIV,
  parameter logic [7:0] COOL_DIV     = DEF_COOL_DIV,
  parameter logic [7:0] RPM_STEP     = DEF_RPM_STEP,
  parameter logic [7:0] RPM_MAX      = DEF_RPM_MAX,
  parameter logic [7:0] AGIT_PERIOD  = DEF_AGIT_PERIOD
) (
  input logic           clk,
  input logic           reset,
  washer_plant_if.slave plant
);
  localparam logic [1:0] ST_IDLE = SP_IDLE;
  localparam logic [1:0] ST_UP   = SP_UP;
  localparam logic [1:0] ST_RUN  = SP_RUN;
  localparam logic [1:0] ST_DOWN = SP_DOWN;

  logic       w_tick;
  logic [7:0] r_level, r_temp, r_rpm, r_heat_cnt, r_cool_cnt, r_agit_cnt;
  logic [1:0] r_spin;
  logic       r_agit_dir;
  logic [3:0] r_fault;

  logic [7:0] w_level_nxt, w_temp_nxt, w_heat_nxt, w_cool_nxt, w_agit_nxt;
  logic [7:0] w_rpm_nxt, w_rpm_up, w_rpm_dn;
  logic [1:0] w_spin_nxt;
  logic       w_dir_nxt, w_go_up, w_go_down;
  logic       w_flt_conflict, w_flt_overflow, w_flt_dry, w_flt_unbal;
  logic [3:0] w_fault_set;
  logic       w_full, w_empty;

  washer_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (reset),
    .o_tick (w_tick)
  );

`ifdef WASHER_PLANT_HYST_EN
  logic r_full, r_empty;

  // hysteresis flags follow the level written on the same tick edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else if (w_tick) begin
      if (w_level_nxt >= FULL_THRESH)              r_full <= 1'b1;
      else if (w_level_nxt < FULL_THRESH - 8'd8)   r_full <= 1'b0;
      if (w_level_nxt <= EMPTY_THRESH)             r_empty <= 1'b1;
      else if (w_level_nxt > EMPTY_THRESH + 8'd8)  r_empty <= 1'b0;
    end
  end

  assign w_full  = r_full;
  assign w_empty = r_empty;
`else
  assign w_full  = (r_level >= FULL_THRESH);
  assign w_empty = (r_level <= EMPTY_THRESH);
`endif

  // tank level: fill or drain with saturation, conflicting valves hold level
  always_comb begin
    w_level_nxt    = r_level;
    w_flt_conflict = 1'b0;
    w_flt_overflow = 1'b0;
    if (plant.water_in && plant.drain) begin
      w_flt_conflict = 1'b1;
    end else if (plant.water_in) begin
      w_flt_overflow = (r_level >= LEVEL_MAX);
      w_level_nxt    = sat_add(r_level, FILL_RATE, LEVEL_MAX);
    end else if (plant.drain) begin
      w_level_nxt    = sat_sub(r_level, DRAIN_RATE);
    end
  end

  // temperature: fresh fill resets to inlet temp, heater raises, idle cools toward ambient
  always_comb begin
    w_temp_nxt = r_temp;
    w_heat_nxt = r_heat_cnt;
    w_cool_nxt = r_cool_cnt;
    w_flt_dry  = 1'b0;
    if (plant.water_in && (r_level == 8'd0)) begin
      w_temp_nxt = TEMP_INIT;
      w_heat_nxt = 8'd0;
      w_cool_nxt = 8'd0;
    end else if (plant.heat_r) begin
      w_cool_nxt = 8'd0;
      if (w_empty) begin
        w_flt_dry = 1'b1;
      end else if (r_heat_cnt >= HEAT_DIV - 8'd1) begin
        w_heat_nxt = 8'd0;
        if (r_temp != 8'hFF) w_temp_nxt = r_temp + 8'd1;
      end else begin
        w_heat_nxt = r_heat_cnt + 8'd1;
      end
    end else begin
      w_heat_nxt = 8'd0;
      if (r_cool_cnt >= COOL_DIV - 8'd1) begin
        w_cool_nxt = 8'd0;
        if (r_temp > TEMP_INIT)      w_temp_nxt = r_temp - 8'd1;
        else if (r_temp < TEMP_INIT) w_temp_nxt = r_temp + 8'd1;
      end else begin
        w_cool_nxt = r_cool_cnt + 8'd1;
      end
    end
  end

  // agitator flips direction every AGIT_PERIOD ticks while washing a full tank
  always_comb begin
    w_agit_nxt = 8'd0;
    w_dir_nxt  = r_agit_dir;
    if (plant.wash && w_full) begin
      if (r_agit_cnt >= AGIT_PERIOD - 8'd1) w_dir_nxt  = ~r_agit_dir;
      else                                  w_agit_nxt = r_agit_cnt + 8'd1;
    end
  end

  // spin FSM; a transition tick already applies the destination's ramp step
  always_comb begin
    w_rpm_up    = sat_add(r_rpm, RPM_STEP, RPM_MAX);
    w_rpm_dn    = sat_sub(r_rpm, RPM_STEP);
    w_spin_nxt  = r_spin;
    w_rpm_nxt   = r_rpm;
    w_flt_unbal = 1'b0;
    w_go_up     = 1'b0;
    w_go_down   = 1'b0;
    case (r_spin)
      ST_IDLE: begin
        if (plant.speed) begin
          if (w_empty) w_go_up     = 1'b1;
          else         w_flt_unbal = 1'b1;
        end
      end
      ST_UP, ST_RUN: begin
        if (!w_empty) begin
          w_flt_unbal = 1'b1;
          w_go_down   = 1'b1;
        end else if (!plant.speed) begin
          w_go_down   = 1'b1;
        end else if (r_spin == ST_UP) begin
          w_go_up     = 1'b1;
        end
      end
      ST_DOWN: begin
        if (plant.speed && w_empty) w_go_up   = 1'b1;
        else                        w_go_down = 1'b1;
      end
      default: w_spin_nxt = ST_IDLE;
    endcase
    if (w_go_up) begin
      w_rpm_nxt  = w_rpm_up;
      w_spin_nxt = (w_rpm_up == RPM_MAX) ? ST_RUN : ST_UP;
    end else if (w_go_down) begin
      w_rpm_nxt  = w_rpm_dn;
      w_spin_nxt = (w_rpm_dn == 8'd0) ? ST_IDLE : ST_DOWN;
    end
  end

  // collect this tick's fault events into their bit positions
  always_comb begin
    w_fault_set                 = 4'b0000;
    w_fault_set[FLT_CONFLICT]   = w_flt_conflict;
    w_fault_set[FLT_OVERFLOW]   = w_flt_overflow;
    w_fault_set[FLT_DRY_HEAT]   = w_flt_dry;
    w_fault_set[FLT_UNBALANCED] = w_flt_unbal;
  end

  // all plant state advances on tick edges only; faults accumulate until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level    <= 8'd0;
      r_temp     <= TEMP_INIT;
      r_rpm      <= 8'd0;
      r_heat_cnt <= 8'd0;
      r_cool_cnt <= 8'd0;
      r_agit_cnt <= 8'd0;
      r_agit_dir <= 1'b0;
      r_spin     <= ST_IDLE;
      r_fault    <= 4'b0000;
    end else if (w_tick) begin
      r_level    <= w_level_nxt;
      r_temp     <= w_temp_nxt;
      r_rpm      <= w_rpm_nxt;
      r_heat_cnt <= w_heat_nxt;
      r_cool_cnt <= w_cool_nxt;
      r_agit_cnt <= w_agit_nxt;
      r_agit_dir <= w_dir_nxt;
      r_spin     <= w_spin_nxt;
      r_fault    <= r_fault | w_fault_set;
    end
  end

  assign plant.full     = w_full;
  assign plant.empty    = w_empty;
  assign plant.cold     = (r_temp < TEMP_TARGET);
  assign plant.level    = r_level;
  assign plant.temp     = r_temp;
  assign plant.rpm      = r_rpm;
  assign plant.agit_dir = r_agit_dir;
  assign plant.fault    = r_fault;
endmodule

// File: tb/tb_washer_plant.sv
// Directed bench for washer_plant: default plant (one tick per clock) plus a
// second instance with a divided time base.
module tb_washer_plant;
  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic resetB = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  washer_plant_if ifA();
  washer_plant_if ifB();

  washer_plant dutA (
    .clk   (clk),
    .reset (reset),
    .plant (ifA)
  );

  washer_plant #(.TICK_DIV(4)) dutB (
    .clk   (clk),
    .reset (resetB),
    .plant (ifB)
  );

  always #5 clk = ~clk;

  // single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // drive the actuator commands of the default plant
  task automatic applyStimulus(input logic w, input logic wa, input logic d,
                               input logic s, input logic h);
    ifA.water_in = w;
    ifA.wash     = wa;
    ifA.drain    = d;
    ifA.speed    = s;
    ifA.heat_r   = h;
  endtask

  // advance n clocks, leaving time 1ns past the last rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_level"}, ifA.level, 0);
    checkOutput({tag, "_temp"},  ifA.temp, 15);
    checkOutput({tag, "_rpm"},   ifA.rpm, 0);
    checkOutput({tag, "_agit"},  ifA.agit_dir, 0);
    checkOutput({tag, "_fault"}, ifA.fault, 0);
    checkOutput({tag, "_empty"}, ifA.empty, 1);
    checkOutput({tag, "_full"},  ifA.full, 0);
    checkOutput({tag, "_cold"},  ifA.cold, 1);
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0);
    ifB.water_in = 1'b0;
    ifB.wash     = 1'b0;
    ifB.drain    = 1'b0;
    ifB.speed    = 1'b0;
    ifB.heat_r   = 1'b0;

    step(3);
    checkResetState("rst");
    reset = 1'b1;

    // fill from empty
    applyStimulus(1, 0, 0, 0, 0);
    step(2);
    checkOutput("fill_t2_level", ifA.level, 8);
    checkOutput("fill_t2_empty", ifA.empty, 1);
    step(1);
    checkOutput("fill_t3_level", ifA.level, 12);
    checkOutput("fill_t3_empty", ifA.empty, 0);
    step(36);
    checkOutput("fill_t39_level", ifA.level, 156);
    checkOutput("fill_t39_full",  ifA.full, 0);
    step(1);
    checkOutput("fill_t40_level", ifA.level, 160);
    checkOutput("fill_t40_full",  ifA.full, 1);
    step(10);
    checkOutput("fill_max_level", ifA.level, 200);
    checkOutput("fill_max_fault", ifA.fault, 0);
    step(1);
    checkOutput("ovf_level", ifA.level, 200);
    checkOutput("ovf_fault", ifA.fault, 4'b0010);

    // drain to empty without wrap
    applyStimulus(0, 0, 1, 0, 0);
    step(24);
    checkOutput("drain_t24_level", ifA.level, 8);
    checkOutput("drain_t24_empty", ifA.empty, 1);
    step(1);
    checkOutput("drain_t25_level", ifA.level, 0);
    step(1);
    checkOutput("drain_nowrap", ifA.level, 0);

    // refill to 160 then heat 15 -> 40 in 250 ticks
    applyStimulus(1, 0, 0, 0, 0);
    step(40);
    checkOutput("refill_level", ifA.level, 160);
    applyStimulus(0, 0, 0, 0, 1);
    step(249);
    checkOutput("heat_t249_temp", ifA.temp, 39);
    checkOutput("heat_t249_cold", ifA.cold, 1);
    step(1);
    checkOutput("heat_t250_temp", ifA.temp, 40);
    checkOutput("heat_t250_cold", ifA.cold, 0);

    // agitator on a full tank
    applyStimulus(0, 1, 0, 0, 0);
    step(4);
    checkOutput("agit_t4", ifA.agit_dir, 0);
    step(1);
    checkOutput("agit_t5", ifA.agit_dir, 1);
    step(5);
    checkOutput("agit_t10", ifA.agit_dir, 0);
    checkOutput("agit_temp", ifA.temp, 40);

    // drain, then heat with an empty tank
    applyStimulus(0, 0, 1, 0, 0);
    step(20);
    checkOutput("drain2_level", ifA.level, 0);
    applyStimulus(0, 0, 0, 0, 1);
    step(12);
    checkOutput("dry_temp",  ifA.temp, 40);
    checkOutput("dry_fault", ifA.fault, 4'b0110);

    // spin up and down on an empty tank
    applyStimulus(0, 0, 0, 1, 0);
    step(1);
    checkOutput("spin_t1", ifA.rpm, 16);
    step(13);
    checkOutput("spin_t14", ifA.rpm, 224);
    step(1);
    checkOutput("spin_t15", ifA.rpm, 240);
    step(2);
    checkOutput("spin_plateau", ifA.rpm, 240);
    applyStimulus(0, 0, 0, 0, 0);
    step(1);
    checkOutput("spindn_t1", ifA.rpm, 224);
    step(14);
    checkOutput("spindn_t15", ifA.rpm, 0);
    step(1);
    checkOutput("spindn_idle", ifA.rpm, 0);

    // spin request with water in the drum
    applyStimulus(1, 0, 0, 0, 0);
    step(25);
    checkOutput("fill100_level", ifA.level, 100);
    applyStimulus(0, 0, 0, 1, 0);
    step(3);
    checkOutput("unbal_rpm",   ifA.rpm, 0);
    checkOutput("unbal_fault", ifA.fault, 4'b1110);

    // conflicting valves hold level
    applyStimulus(0, 0, 1, 0, 0);
    step(6);
    checkOutput("drain52_level", ifA.level, 52);
    applyStimulus(1, 0, 1, 0, 0);
    step(3);
    checkOutput("conflict_level", ifA.level, 52);
    checkOutput("conflict_fault", ifA.fault, 4'b1111);

    // reset asserted mid-spin takes effect within the cycle
    applyStimulus(0, 0, 1, 0, 0);
    step(7);
    checkOutput("drain3_level", ifA.level, 0);
    applyStimulus(0, 0, 0, 1, 0);
    step(5);
    checkOutput("prerst_rpm", ifA.rpm, 80);
    #3;
    reset = 1'b0;
    #1;
    checkResetState("midrst");
    step(1);
    applyStimulus(0, 0, 0, 0, 0);
    reset = 1'b1;

    // water rising during spin-up aborts to ramp-down with an unbalance fault
    applyStimulus(0, 0, 0, 1, 0);
    step(3);
    checkOutput("abort_pre_rpm", ifA.rpm, 48);
    applyStimulus(1, 0, 0, 1, 0);
    step(4);
    checkOutput("abort_level", ifA.level, 16);
    checkOutput("abort_rpm",   ifA.rpm, 80);
    checkOutput("abort_fault", ifA.fault, 4'b1000);
    applyStimulus(0, 0, 0, 0, 0);

    // divided time base: level steps once per 4 clocks
    resetB       = 1'b1;
    ifB.water_in = 1'b1;
    step(3);
    checkOutput("div4_c3_level", ifB.level, 0);
    step(1);
    checkOutput("div4_c4_level", ifB.level, 4);
    step(3);
    checkOutput("div4_c7_level", ifB.level, 4);
    step(1);
    checkOutput("div4_c8_level", ifB.level, 8);
    checkOutput("div4_empty",    ifB.empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
